// File: rtl/router_pkg.sv
// Shared constants and header-field helpers for the packet router.
package router_pkg;

   localparam int WIDTH = 8;

   // Destination address 3 does not exist.
   localparam logic [1:0] ADDR_INVALID = 2'b11;

   // Header layout: payload length in [7:2], destination address in [1:0].
   function automatic logic [1:0] header_addr(input logic [WIDTH-1:0] hdr);
      return hdr[1:0];
   endfunction

   function automatic logic [5:0] header_len(input logic [WIDTH-1:0] hdr);
      return hdr[7:2];
   endfunction

endpackage

// File: rtl/router_reg_if.sv
// Signal bundle between the router FSM / input port and the datapath register.
interface router_reg_if;
   import router_pkg::*;

   logic             pkt_valid;
   logic             fifo_full;
   logic             detect_add;
   logic             ld_state;
   logic             laf_state;
   logic             full_state;
   logic             lfd_state;
   logic             rst_int_reg;
   logic [WIDTH-1:0] data_in;
   logic             err;
   logic             parity_done;
   logic             low_packet_valid;
   logic [WIDTH-1:0] dout;

   // Side that drives bytes and FSM state flags.
   modport master (
      output pkt_valid, fifo_full, detect_add, ld_state, laf_state,
             full_state, lfd_state, rst_int_reg, data_in,
      input  err, parity_done, low_packet_valid, dout
   );

   // The register block itself.
   modport slave (
      input  pkt_valid, fifo_full, detect_add, ld_state, laf_state,
             full_state, lfd_state, rst_int_reg, data_in,
      output err, parity_done, low_packet_valid, dout
   );

endinterface

// File: rtl/router_reg.sv
// Router datapath register: header latch, full-FIFO holding byte, FIFO output
// byte, running parity check and end-of-packet flags. All outputs registered.
module router_reg #(
   parameter int WIDTH = router_pkg::WIDTH
) (
   input logic          clock,
   input logic          resetn,
   router_reg_if.slave  bus
);
   import router_pkg::*;

   logic [WIDTH-1:0] header_byte;
   logic [WIDTH-1:0] full_state_byte;
   logic [WIDTH-1:0] internal_parity;
   logic [WIDTH-1:0] packet_parity;
   logic [WIDTH-1:0] dout_reg;
   logic             parity_done_reg;
   logic             low_packet_valid_reg;
   logic             err_reg;

   logic             header_ok;

   // A header is only worth keeping if it addresses a real destination.
   assign header_ok = bus.detect_add && bus.pkt_valid &&
                      (header_addr(bus.data_in) != ADDR_INVALID);

   // Header latch: holds the last valid header until the next one.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)
         header_byte <= '0;
      else if (header_ok)
         header_byte <= bus.data_in;
   end

   // Byte towards the FIFO: header first, then live data, then the parked byte.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)
         dout_reg <= '0;
      else if (bus.lfd_state)
         dout_reg <= header_byte;
      else if (bus.ld_state && !bus.fifo_full)
         dout_reg <= bus.data_in;
      else if (bus.laf_state)
         dout_reg <= full_state_byte;
   end

   // Park the byte that arrived while the FIFO could not accept it.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)
         full_state_byte <= '0;
      else if (bus.ld_state && bus.fifo_full)
         full_state_byte <= bus.data_in;
   end

   // Running XOR over header and payload; a byte stalled in FIFO_FULL is not
   // counted again.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)
         internal_parity <= '0;
      else if (bus.detect_add)
         internal_parity <= '0;
      else if (bus.lfd_state && bus.pkt_valid)
         internal_parity <= internal_parity ^ header_byte;
      else if (bus.ld_state && bus.pkt_valid && !bus.full_state)
         internal_parity <= internal_parity ^ bus.data_in;
   end

   // Capture the parity byte carried at the end of the packet.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)
         packet_parity <= '0;
      else if (bus.detect_add)
         packet_parity <= '0;
      else if (bus.ld_state && !bus.pkt_valid)
         packet_parity <= bus.data_in;
   end

   // Parity done once the parity byte reaches the FIFO, directly or after a stall.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)
         parity_done_reg <= 1'b0;
      else if (bus.detect_add)
         parity_done_reg <= 1'b0;
      else if ((bus.ld_state && !bus.fifo_full && !bus.pkt_valid) ||
               (bus.laf_state && low_packet_valid_reg && !parity_done_reg))
         parity_done_reg <= 1'b1;
   end

   // Last byte seen; the FSM's clear request wins over a new set.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)
         low_packet_valid_reg <= 1'b0;
      else if (bus.rst_int_reg)
         low_packet_valid_reg <= 1'b0;
      else if (bus.ld_state && !bus.pkt_valid)
         low_packet_valid_reg <= 1'b1;
   end

   // Compare computed and received parity on every cycle after parity_done.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)
         err_reg <= 1'b0;
      else if (bus.detect_add)
         err_reg <= 1'b0;
      else if (parity_done_reg)
         err_reg <= (internal_parity != packet_parity);
   end

   assign bus.dout             = dout_reg;
   assign bus.parity_done      = parity_done_reg;
   assign bus.low_packet_valid = low_packet_valid_reg;
   assign bus.err              = err_reg;

endmodule

// File: tb/tb_router_reg.sv
// Directed/randomized bench for router_reg. Expected values come from packet
// contents: FIFO byte order and XOR of header plus payload bytes.
module tb_router_reg;
   import router_pkg::*;

   logic clock;
   logic resetn;
   int   n_cmp;
   int   n_bad;

   router_reg_if bus ();

   router_reg #(.WIDTH(8)) dut (
      .clock  (clock),
      .resetn (resetn),
      .bus    (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      bus.pkt_valid   = 1'b0;
      bus.fifo_full   = 1'b0;
      bus.detect_add  = 1'b0;
      bus.ld_state    = 1'b0;
      bus.laf_state   = 1'b0;
      bus.full_state  = 1'b0;
      bus.lfd_state   = 1'b0;
      bus.rst_int_reg = 1'b0;
      bus.data_in     = 8'($urandom);
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] rand_header();
      logic [5:0] len;
      logic [1:0] addr;
      len  = 6'($urandom_range(1, 6));
      addr = 2'($urandom_range(0, 2));
      return {len, addr};
   endfunction

   // Header cycle: detect_add clears done/err flags.
   task automatic send_header(input logic [7:0] hdr);
      idle();
      bus.detect_add = 1'b1;
      bus.pkt_valid  = 1'b1;
      bus.data_in    = hdr;
      step();
      check1("hdr_pd_clear", bus.parity_done, 1'b0);
      check1("hdr_err_clear", bus.err, 1'b0);
   endtask

   // Normal packet without stalls. When abort is set, stop right after the
   // parity byte (flags high) so the caller can test reset.
   task automatic send_normal(input logic [7:0] hdr, input bit bad, input bit abort);
      logic [7:0] pl[$];
      logic [7:0] par;
      int         len;
      len = int'(header_len(hdr));
      par = hdr;
      for (int i = 0; i < len; i++) begin
         pl.push_back(8'($urandom));
         par = par ^ pl[i];
      end
      if (bad) par = ~par;

      send_header(hdr);
      bus.detect_add = 1'b0;
      bus.lfd_state  = 1'b1;
      bus.data_in    = pl[0];
      step();
      check("lfd_dout_hdr", bus.dout, hdr);

      bus.lfd_state = 1'b0;
      bus.ld_state  = 1'b1;
      for (int i = 0; i < len; i++) begin
         bus.data_in = pl[i];
         step();
         check("payload_dout", bus.dout, pl[i]);
         check1("payload_lpv", bus.low_packet_valid, 1'b0);
      end

      bus.pkt_valid = 1'b0;
      bus.data_in   = par;
      step();
      check("parity_dout", bus.dout, par);
      check1("parity_pd", bus.parity_done, 1'b1);
      check1("parity_lpv", bus.low_packet_valid, 1'b1);
      if (abort) return;

      // Clear request coincides with ld_state && !pkt_valid; clear must win.
      bus.rst_int_reg = 1'b1;
      step();
      check1("rst_int_lpv", bus.low_packet_valid, 1'b0);
      check1("err_value", bus.err, bad);

      idle();
      step();
      check1("err_hold", bus.err, bad);
      check1("pd_hold", bus.parity_done, 1'b1);
      $display("txn packet hdr=%h len=%0d bad=%0d parity=%h err=%b",
               hdr, len, bad, par, bus.err);
   endtask

   // Packet of length 3 with a FIFO stall mid-payload and on the parity byte.
   task automatic send_full(input logic [7:0] hdr);
      logic [7:0] p0;
      logic [7:0] p2;
      logic [7:0] par;
      p0  = 8'($urandom);
      p2  = 8'($urandom);
      par = hdr ^ p0 ^ 8'hA5 ^ p2;

      send_header(hdr);
      bus.detect_add = 1'b0;
      bus.lfd_state  = 1'b1;
      bus.data_in    = p0;
      step();
      check("full_lfd_dout", bus.dout, hdr);

      bus.lfd_state = 1'b0;
      bus.ld_state  = 1'b1;
      step();
      check("full_p0_dout", bus.dout, p0);

      bus.fifo_full = 1'b1;
      bus.data_in   = 8'hA5;
      step();
      check("full_dout_hold", bus.dout, p0);

      // Byte still presented while in FIFO_FULL: must not re-enter parity.
      bus.full_state = 1'b1;
      step();
      check("full_state_hold", bus.dout, p0);

      bus.full_state = 1'b0;
      bus.ld_state   = 1'b0;
      bus.fifo_full  = 1'b0;
      bus.laf_state  = 1'b1;
      bus.data_in    = 8'($urandom);
      step();
      check("laf_dout_a5", bus.dout, 8'hA5);

      bus.laf_state = 1'b0;
      bus.ld_state  = 1'b1;
      bus.data_in   = p2;
      step();
      check("full_p2_dout", bus.dout, p2);

      bus.fifo_full = 1'b1;
      bus.pkt_valid = 1'b0;
      bus.data_in   = par;
      step();
      check("full_par_hold", bus.dout, p2);
      check1("full_par_lpv", bus.low_packet_valid, 1'b1);
      check1("full_par_pd", bus.parity_done, 1'b0);

      bus.ld_state  = 1'b0;
      bus.fifo_full = 1'b0;
      bus.laf_state = 1'b1;
      bus.data_in   = 8'($urandom);
      step();
      check("laf_dout_par", bus.dout, par);
      check1("laf_pd", bus.parity_done, 1'b1);

      idle();
      bus.rst_int_reg = 1'b1;
      step();
      check1("full_err", bus.err, 1'b0);
      check1("full_lpv_clr", bus.low_packet_valid, 1'b0);
      idle();
      step();
      $display("txn full packet hdr=%h parity=%h err=%b", hdr, par, bus.err);
   endtask

   initial begin
      logic [7:0] hdr;
      n_cmp  = 0;
      n_bad  = 0;
      resetn = 1'b0;
      idle();
      step();
      step();
      check("reset_dout", bus.dout, 8'h00);
      check1("reset_err", bus.err, 1'b0);
      check1("reset_pd", bus.parity_done, 1'b0);
      check1("reset_lpv", bus.low_packet_valid, 1'b0);
      $display("txn reset dout=%h err=%b pd=%b lpv=%b",
               bus.dout, bus.err, bus.parity_done, bus.low_packet_valid);
      resetn = 1'b1;
      step();

      send_normal(8'h0D, 1'b0, 1'b0);
      send_normal(8'h0D, 1'b1, 1'b0);
      send_normal(8'h0D, 1'b0, 1'b0);

      for (int k = 0; k < 6; k++) begin
         send_normal(rand_header(), 1'($urandom_range(0, 1)), 1'b0);
      end

      send_full(8'h0E);

      // Invalid address: previously latched header must survive.
      hdr = rand_header();
      send_normal(hdr, 1'b0, 1'b0);
      send_header(8'hFF);
      bus.detect_add = 1'b0;
      bus.lfd_state  = 1'b1;
      step();
      check("invalid_addr_hdr", bus.dout, hdr);
      $display("txn invalid header ff, kept header=%h", bus.dout);
      idle();
      step();

      // Asynchronous reset in the middle of a packet, with no clock edge.
      send_normal(8'h09, 1'b0, 1'b1);
      #2;
      resetn = 1'b0;
      #1;
      check("async_dout", bus.dout, 8'h00);
      check1("async_pd", bus.parity_done, 1'b0);
      check1("async_lpv", bus.low_packet_valid, 1'b0);
      idle();
      step();
      resetn = 1'b1;
      bus.lfd_state = 1'b1;
      bus.pkt_valid = 1'b1;
      step();
      check("post_reset_hdr", bus.dout, 8'h00);
      $display("txn async reset mid-packet dout=%h", bus.dout);
      idle();
      step();

      send_normal(rand_header(), 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/router_reg.md
Name: router_reg

Overview:
- Datapath register block of the 1-to-3 packet router. It sits between the input port and the FIFOs, under control of the router FSM.
- Latches the header byte, buffers the byte arriving while the FIFO is full, and drives the byte bound for the FIFO on `dout`.
- Computes running XOR parity over header and payload, compares it with the packet's parity byte, and flags `err`.
- Produces `low_packet_valid` (last byte received) and `parity_done` for the FSM.

Parameters:
- WIDTH, 8, data byte width (header, payload, parity).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- resetn  in  1  asynchronous active-low reset.
- pkt_valid  in  1  high while header/payload bytes are on data_in; low on the parity byte.
- fifo_full  in  1  selected destination FIFO is full.
- detect_add  in  1  FSM in DECODE_ADDRESS; header on data_in.
- ld_state  in  1  FSM in LOAD_DATA.
- laf_state  in  1  FSM in LOAD_AFTER_FULL.
- full_state  in  1  FSM in FIFO_FULL_STATE.
- lfd_state  in  1  FSM in LOAD_FIRST_DATA.
- rst_int_reg  in  1  FSM request to clear low_packet_valid.
- data_in  in  8  incoming byte.
- err  out  1  parity mismatch for the completed packet.
- parity_done  out  1  packet parity byte has been captured.
- low_packet_valid  out  1  last (parity) byte of the packet has arrived.
- dout  out  8  registered byte written to the FIFO.

Behaviour:
- All registers are 0 on reset: dout, header_byte, full_state_byte, internal_parity, packet_parity, parity_done, low_packet_valid, err. Reset acts asynchronously.
- Every output is registered, with one cycle of latency from the qualifying input.

header_byte:
- Loads data_in when detect_add && pkt_valid && data_in[1:0] != 2'b11.
- Otherwise it holds. Address 3 is invalid and never latched.

dout (priority order):
- lfd_state: dout <= header_byte.
- else ld_state && !fifo_full: dout <= data_in.
- else laf_state: dout <= full_state_byte.
- else dout holds.

full_state_byte:
- Loads data_in when ld_state && fifo_full.
- Otherwise it holds.

internal_parity:
- detect_add: cleared to 0.
- else lfd_state && pkt_valid: internal_parity ^= header_byte.
- else ld_state && pkt_valid && !full_state: internal_parity ^= data_in.
- else it holds.

packet_parity:
- detect_add: cleared to 0.
- else ld_state && !pkt_valid: loads data_in (the parity byte).

parity_done:
- detect_add: cleared to 0.
- else it is set to 1 when (ld_state && !fifo_full && !pkt_valid) or (laf_state && low_packet_valid && !parity_done).
- Once set it stays set until the next detect_add.

low_packet_valid:
- rst_int_reg: cleared to 0. This has priority.
- else ld_state && !pkt_valid: set to 1.
- else it holds.

err:
- detect_add: cleared to 0.
- else, in every cycle where parity_done == 1: err <= (internal_parity != packet_parity).
- else it holds.
- err is therefore valid one cycle after parity_done rises.

Simultaneous events:
- detect_add beats the parity, parity_done and err updates in the same cycle.
- rst_int_reg beats the low_packet_valid set.
- A reset asserted mid-packet returns every register to 0 immediately.

Decomposition:
- Shared package router_pkg:
  - WIDTH = 8
  - ADDR_INVALID = 2'b11
  - header field split: payload length = [7:2], address = [1:0]
- No sub-module needed. Single flat module; a small parity-checker sub-module router_parity_chk (internal_parity, packet_parity, err) is acceptable.

Test Plan:
- Reset: assert resetn=0 -> dout, err, parity_done and low_packet_valid are all 0. Then release.
- Good packet:
  - Stimulus: header 8'h0D (len 3, addr 1) with detect_add=1, pkt_valid=1. Then lfd_state for 1 cycle, then 3 random payloads with ld_state=1. Then pkt_valid=0 with data_in = XOR of all four bytes.
  - Response: dout shows header then payloads then parity, one cycle each. parity_done=1 and low_packet_valid=1 after the parity edge. err=0 one cycle later.
- Bad packet: same stimulus but the parity byte is inverted -> parity_done=1, and err=1 one cycle later. A following detect_add clears err, parity_done and internal_parity.
- FIFO full:
  - Stimulus: during ld_state assert fifo_full with data_in=8'hA5 -> dout holds and full_state_byte=8'hA5.
  - Then laf_state -> dout=8'hA5.
  - Payload XOR is excluded while full_state=1.
- Invalid address: detect_add with data_in=8'hFF (addr 3) -> header_byte is unchanged, and a later lfd_state outputs the previous header.
- rst_int_reg: with low_packet_valid=1, pulse rst_int_reg for 1 cycle -> low_packet_valid=0 next edge, even if ld_state && !pkt_valid are also asserted.
